// File: rtl/fir_pkg.sv
// Shared types and helpers for the FIR tap accumulator datapath.
package fir_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  localparam int IN_W_D  = 9;
  localparam int ACC_W_D = 12;
  localparam int OUT_W_D = 8;
  localparam int SAT_W   = 32;

  typedef struct packed {
    logic signed [SAT_W-1:0] value;
    logic                    sat;
  } sat_t;

  // Clip a signed value to the range of a signed 'width'-bit number.
  function automatic sat_t sat_signed(input logic signed [SAT_W-1:0] value, input int width);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    sat_t r;
    hi = (32'sd1 <<< (width - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    r.value = value;
    r.sat   = 1'b0;
    if (value > hi) begin
      r.value = hi;
      r.sat   = 1'b1;
    end else if (value < lo) begin
      r.value = lo;
      r.sat   = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fir_sat_shift.sv
// Combinational arithmetic right shift (floor) followed by signed saturation.
module fir_sat_shift
  import fir_pkg::*;
#(
  parameter int ACC_W = ACC_W_D,
  parameter int OUT_W = OUT_W_D,
  parameter int SHIFT = 0
) (
  input  logic [ACC_W-1:0] acc,
  output logic [OUT_W-1:0] data,
  output logic             sat
);

  logic signed [ACC_W-1:0] shifted;
  logic signed [SAT_W-1:0] ext;
  sat_t                    r;
  logic                    sat_unused_bits;

  assign shifted = $signed(acc) >>> SHIFT;
  assign ext     = {{(SAT_W-ACC_W){shifted[ACC_W-1]}}, shifted};

  always_comb begin
    r = sat_signed(ext, OUT_W);
  end

  assign data = r.value[OUT_W-1:0];
  assign sat  = r.sat;
  assign sat_unused_bits = ^r.value[SAT_W-1:OUT_W];

endmodule

// File: rtl/fir_tap_accumulator.sv
// Accumulates NTAPS signed tap sums per frame and emits one scaled, saturated
// sample through a one-entry valid/ready output buffer.
module fir_tap_accumulator
  import fir_pkg::*;
#(
  parameter int NTAPS = 8,
  parameter int IN_W  = IN_W_D,
  parameter int ACC_W = ACC_W_D,
  parameter int OUT_W = OUT_W_D,
  parameter int SHIFT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sat,
  output logic             busy
);

  localparam int CNT_W = (NTAPS > 1) ? $clog2(NTAPS) : 1;

  // Handshake: a beat moves on any cycle where valid && ready; data is sampled
  // only then, and out_valid/out_data/out_sat hold steady until their transfer.
  state_t             state;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic               in_xfer;
  logic               out_xfer;
  logic               start;
  logic               last;
  logic [ACC_W-1:0]   in_ext;
  logic [ACC_W-1:0]   acc_next;
  logic [CNT_W-1:0]   cnt_next;
  logic [OUT_W-1:0]   sat_data;
  logic               sat_flag;

  always_comb begin
    in_ready = 1'b1;
    if (clr)
      in_ready = 1'b0;
    else if (state == HOLD)
      in_ready = out_ready;
  end

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;
  assign in_ext   = {{(ACC_W-IN_W){in_data[IN_W-1]}}, in_data};

  // HOLD with an input transfer restarts a frame exactly like IDLE.
  assign start    = (state != ACCUM);
  assign acc_next = start ? in_ext : acc + in_ext;
  assign cnt_next = start ? CNT_W'(1) : cnt + CNT_W'(1);
  assign last     = start ? (NTAPS == 1) : (cnt == CNT_W'(NTAPS - 1));
  assign busy     = (state == ACCUM);

  fir_sat_shift #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_sat (
    .acc  (acc_next),
    .data (sat_data),
    .sat  (sat_flag)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (clr) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      if (out_xfer) begin
        out_valid <= 1'b0;
        if (state == HOLD)
          state <= IDLE;
      end
      if (in_xfer) begin
        acc <= acc_next;
        if (last) begin
          cnt       <= '0;
          out_valid <= 1'b1;
          out_data  <= sat_data;
          out_sat   <= sat_flag;
          state     <= HOLD;
        end else begin
          cnt   <= cnt_next;
          state <= ACCUM;
        end
      end
    end
  end

endmodule

// File: tb/tb_fir_tap_accumulator.sv
// Directed bench: table of frames plus hand-written reset, clr and back-pressure sequences.
module tb_fir_tap_accumulator;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       in_valid;
  logic [8:0] in_data;
  logic       out_ready;
  logic       in_ready,   in_ready2;
  logic       out_valid,  out_valid2;
  logic [7:0] out_data,   out_data2;
  logic       out_sat,    out_sat2;
  logic       busy,       busy2;

  int n_cmp;
  int n_err;

  typedef struct {
    int base;
    int step;
    int exp0;
    int sat0;
    int exp2;
    int sat2;
  } vec_t;

  vec_t vecs[9];

  fir_tap_accumulator #(.NTAPS(8), .SHIFT(0)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sat(out_sat), .busy(busy)
  );

  fir_tap_accumulator #(.NTAPS(8), .SHIFT(2)) dut_s2 (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
    .out_sat(out_sat2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  // Feed 8 taps base+i*step with out_ready=1, then check both outputs.
  task automatic run_frame(input int base, input int step, input int exp0, input int sat0,
                           input int exp2, input int sat2, input string tag);
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = 9'(base + i * step);
      step_clk();
      if (i < 7) check({tag, " busy"}, int'(busy), 1);
    end
    in_valid = 1'b0;
    check({tag, " busy_end"}, int'(busy), 0);
    check({tag, " valid"}, int'(out_valid), 1);
    check({tag, " data"}, int'($signed(out_data)), exp0);
    check({tag, " sat"}, int'(out_sat), sat0);
    check({tag, " valid_s2"}, int'(out_valid2), 1);
    check({tag, " data_s2"}, int'($signed(out_data2)), exp2);
    check({tag, " sat_s2"}, int'(out_sat2), sat2);
  endtask

  task automatic feed(input int val, input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = 9'(val);
      step_clk();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    // base, step, exp SHIFT=0, sat, exp SHIFT=2, sat
    vecs[0] = '{1,    1,   36, 0,    9, 0};
    vecs[1] = '{255,  0,  127, 1,  127, 1};
    vecs[2] = '{-256, 0, -128, 1, -128, 1};
    vecs[3] = '{3,    0,   24, 0,    6, 0};
    vecs[4] = '{-3,   0,  -24, 0,   -6, 0};
    vecs[5] = '{16,   0,  127, 1,   32, 0};
    vecs[6] = '{-16,  0, -128, 0,  -32, 0};
    vecs[7] = '{-1,  -1,  -36, 0,   -9, 0};
    vecs[8] = '{15,   0,  120, 0,   30, 0};

    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    step_clk();
    step_clk();
    check("rst out_valid", int'(out_valid), 0);
    check("rst out_data", int'(out_data), 0);
    check("rst out_sat", int'(out_sat), 0);
    check("rst busy", int'(busy), 0);
    check("rst in_ready", int'(in_ready), 1);
    rst_n = 1'b1;
    step_clk();

    // Back-to-back frames: each first tap lands in the HOLD cycle of the previous frame.
    for (int v = 0; v < 9; v++)
      run_frame(vecs[v].base, vecs[v].step, vecs[v].exp0, vecs[v].sat0,
                vecs[v].exp2, vecs[v].sat2, $sformatf("vec%0d", v));
    step_clk();
    check("drain out_valid", int'(out_valid), 0);

    // Reset asserted mid-frame.
    feed(10, 3);
    check("mid busy", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async rst out_valid", int'(out_valid), 0);
    check("async rst busy", int'(busy), 0);
    check("async rst in_ready", int'(in_ready), 1);
    step_clk();
    rst_n = 1'b1;
    step_clk();
    run_frame(1, 0, 8, 0, 2, 0, "post_rst");
    step_clk();

    // clr discards a partial frame and blocks the input presented with it.
    feed(10, 3);
    clr = 1'b1; in_valid = 1'b1; in_data = 9'd100;
    #1;
    check("clr in_ready", int'(in_ready), 0);
    step_clk();
    clr = 1'b0; in_valid = 1'b0;
    check("clr busy", int'(busy), 0);
    run_frame(1, 0, 8, 0, 2, 0, "post_clr");
    step_clk();

    // Back-pressure then same-cycle hand-off into the next frame.
    out_ready = 1'b0;
    feed(2, 8);
    in_valid = 1'b1; in_data = 9'd5;
    for (int c = 0; c < 5; c++) begin
      check("bp out_valid", int'(out_valid), 1);
      check("bp out_data", int'($signed(out_data)), 16);
      check("bp in_ready", int'(in_ready), 0);
      step_clk();
    end
    out_ready = 1'b1;
    #1;
    check("handoff in_ready", int'(in_ready), 1);
    step_clk();
    check("handoff out_valid", int'(out_valid), 0);
    check("handoff busy", int'(busy), 1);
    feed(5, 7);
    check("handoff frame valid", int'(out_valid), 1);
    check("handoff frame data", int'($signed(out_data)), 40);
    check("handoff frame data_s2", int'($signed(out_data2)), 10);

    // clr drops a pending output held by back-pressure.
    out_ready = 1'b0;
    step_clk();
    check("hold before clr", int'(out_valid), 1);
    clr = 1'b1;
    step_clk();
    clr = 1'b0;
    check("clr drops output", int'(out_valid), 0);
    check("clr state idle", int'(busy), 0);
    out_ready = 1'b1;
    step_clk();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
